// File: rtl/muldiv_pkg.sv
// Shared types, opcode constants and sign helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [1:0] ALUOP_RTYPE   = 2'b10;

    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic neg);
        md_abs = neg ? (~v + 32'd1) : v;
    endfunction

    // acc holds the unsigned product, or {remainder, quotient} for divides.
    function automatic logic [31:0] md_fixup(input logic [2:0]  f3,
                                             input logic [63:0] acc,
                                             input logic        neg_main,
                                             input logic        neg_rem);
        logic [63:0] prod;
        logic [31:0] quo;
        logic [31:0] rem;
        prod = neg_main ? (~acc + 64'd1) : acc;
        quo  = neg_main ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem  = neg_rem  ? (~acc[63:32] + 32'd1) : acc[63:32];
        case (f3)
            F3_MUL:                      md_fixup = prod[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU: md_fixup = prod[63:32];
            F3_DIV, F3_DIVU:             md_fixup = quo;
            default:                     md_fixup = rem;
        endcase
    endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M mul/div in EX; 34 cycles in EX per op (2 for divide-by-zero/overflow cases).
// Backpressure: mdStall holds the front of the pipeline from first sighting until the op is done.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            flush,
    input  logic [XLEN-1:0] exLHSRegisterValue,
    input  logic [XLEN-1:0] exRHSRegisterValue,
    input  logic [4:0]      exWriteRegisterIndex,
    input  logic [2:0]      exFunct3,
    input  logic [6:0]      exFunct7,
    input  logic [1:0]      exAluOp,
    output logic            mdStall,
    output logic            mdResultValid,
    output logic [XLEN-1:0] mdResult,
    output logic [4:0]      mdWriteRegisterIndex
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_count;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic [31:0] r_opnd;
    logic [63:0] r_acc;
    logic        r_neg_main;
    logic        r_neg_rem;
    logic [31:0] r_result;

    logic        w_start;
    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_sa;
    logic        w_sb;
    logic        w_div0;
    logic        w_ovf;
    logic        w_special;
    logic [31:0] w_special_res;
    logic [32:0] w_sum;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic [63:0] w_mul_step;
    logic [63:0] w_div_step;
    logic [63:0] w_acc_step;

    assign w_start = (exAluOp == ALUOP_RTYPE) && (exFunct7 == FUNCT7_MULDIV) && !flush;

    always_comb begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
        case (exFunct3)
            F3_MULHSU:        w_b_signed = 1'b0;
            F3_MULHU, F3_DIVU,
            F3_REMU: begin
                w_a_signed = 1'b0;
                w_b_signed = 1'b0;
            end
            default: ;
        endcase
    end

    assign w_sa = w_a_signed & exLHSRegisterValue[31];
    assign w_sb = w_b_signed & exRHSRegisterValue[31];

    assign w_div0    = exFunct3[2] && (exRHSRegisterValue == 32'd0);
    assign w_ovf     = ((exFunct3 == F3_DIV) || (exFunct3 == F3_REM)) &&
                       (exLHSRegisterValue == 32'h8000_0000) &&
                       (exRHSRegisterValue == 32'hFFFF_FFFF);
    assign w_special = w_div0 || w_ovf;

    always_comb begin
        w_special_res = 32'd0;
        if (w_div0)
            w_special_res = exFunct3[1] ? exLHSRegisterValue : 32'hFFFF_FFFF;
        else if (exFunct3 == F3_DIV)
            w_special_res = 32'h8000_0000;
    end

    // Multiply: add multiplicand into the high half, then shift the whole accumulator right.
    assign w_sum      = {1'b0, r_acc[63:32]} + {1'b0, r_opnd};
    assign w_mul_step = r_acc[0] ? {w_sum, r_acc[31:1]} : {1'b0, r_acc[63:32], r_acc[31:1]};

    // Divide: remainder in the high half, dividend shifts out of / quotient into the low half.
    assign w_rem_sh   = {r_acc[63:32], r_acc[31]};
    assign w_diff     = w_rem_sh - {1'b0, r_opnd};
    assign w_div_step = w_diff[32] ? {w_rem_sh[31:0], r_acc[30:0], 1'b0}
                                   : {w_diff[31:0],   r_acc[30:0], 1'b1};

    assign w_acc_step = r_funct3[2] ? w_div_step : w_mul_step;

    always_comb begin
        w_state_nxt = r_state;
        mdStall     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    mdStall     = 1'b1;
                    w_state_nxt = w_special ? DONE : BUSY;
                end
            end
            BUSY: begin
                mdStall = 1'b1;
                if (flush)
                    w_state_nxt = IDLE;
                else if (r_count == 5'd31)
                    w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state    <= IDLE;
            r_count    <= 5'd0;
            r_funct3   <= 3'd0;
            r_rd       <= 5'd0;
            r_opnd     <= 32'd0;
            r_acc      <= 64'd0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_result   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_start) begin
                r_count    <= 5'd0;
                r_funct3   <= exFunct3;
                r_rd       <= exWriteRegisterIndex;
                r_neg_main <= w_sa ^ w_sb;
                r_neg_rem  <= w_sa;
                if (exFunct3[2]) begin
                    r_opnd <= md_abs(exRHSRegisterValue, w_sb);
                    r_acc  <= {32'd0, md_abs(exLHSRegisterValue, w_sa)};
                end else begin
                    r_opnd <= md_abs(exLHSRegisterValue, w_sa);
                    r_acc  <= {32'd0, md_abs(exRHSRegisterValue, w_sb)};
                end
                if (w_special)
                    r_result <= w_special_res;
            end else if (r_state == BUSY && !flush) begin
                r_acc   <= w_acc_step;
                r_count <= r_count + 5'd1;
                if (r_count == 5'd31)
                    r_result <= md_fixup(r_funct3, w_acc_step, r_neg_main, r_neg_rem);
            end
        end
    end

    assign mdResultValid        = (r_state == DONE);
    assign mdResult             = r_result;
    assign mdWriteRegisterIndex = r_rd;

endmodule
